// File: rtl/data_mem_pipe_if.sv
// Request/response bus of the pipelined data memory used by the RV32I MEM stage.
// Handshake: a request transfers on a rising edge where req_valid & req_ready; the master
// holds all req_* fields stable while req_valid is high and req_ready is low. rsp_valid is a
// one-cycle strobe with no backpressure, and responses come back in acceptance order.
interface data_mem_pipe_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_pipe.sv
// Pipelined byte-addressable data memory: one load/store per cycle, RV32I size handling,
// fixed READ_LAT response latency and an optional zeroing sweep after reset.
module data_mem_pipe #(
  parameter int ADDR_W         = 16,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_pipe_if.slave bus,
  output logic          fsm_state
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int DEPTH  = 2 ** IDX_W;
  localparam int PIPE_N = (READ_LAT > 1) ? READ_LAT - 1 : 1;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q;
  logic               last_word;

  logic [31:0] mem [DEPTH] = '{default: '0};

  // FSM: INIT sweeps one word per cycle, RUN serves requests
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RESET != 0) state_q <= INIT;
      else                     state_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last_word = (cnt_q == IDX_W'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (last_word) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign bus.req_ready = (state_q == RUN) && !rst;
  assign fsm_state     = state_q;

  // Request decode
  logic             accept;
  logic [IDX_W-1:0] widx;
  logic [1:0]       off;
  logic             req_err;
  logic [3:0]       be;
  logic [31:0]      wlane;
  logic             mem_we;

  assign accept = bus.req_valid & bus.req_ready;
  assign widx   = bus.req_addr[ADDR_W-1:2];
  assign off    = bus.req_addr[1:0];

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'd0:    req_err = 1'b0;
      2'd1:    req_err = off[0];
      2'd2:    req_err = (off != 2'd0);
      default: req_err = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target lanes
  always_comb begin
    be    = 4'b0000;
    wlane = bus.req_wdata;
    case (bus.req_size)
      2'd0: begin
        be    = 4'b0001 << off;
        wlane = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wlane = {2{bus.req_wdata[15:0]}};
      end
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign mem_we = accept & bus.req_we & ~req_err;

  logic [31:0] s_word;

  always_ff @(posedge clk) begin
    if (!rst && state_q == INIT) begin
      mem[cnt_q] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
    s_word <= mem[widx];
  end

  // First response stage: control captured alongside the synchronous word read
  logic       s_valid, s_load, s_err, s_uns;
  logic [1:0] s_size, s_off;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_load  <= 1'b0;
      s_err   <= 1'b0;
      s_uns   <= 1'b0;
      s_size  <= 2'd0;
      s_off   <= 2'd0;
    end else begin
      s_valid <= accept;
      s_load  <= accept & ~bus.req_we & ~req_err;
      s_err   <= accept & req_err;
      s_uns   <= bus.req_unsigned;
      s_size  <= bus.req_size;
      s_off   <= off;
    end
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;

  always_comb begin
    byte_sel = s_word[{s_off, 3'b000} +: 8];
    half_sel = s_off[1] ? s_word[31:16] : s_word[15:0];
    ext      = '0;
    case (s_size)
      2'd0:    ext = s_uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'd1:    ext = s_uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      2'd2:    ext = s_word;
      default: ext = '0;
    endcase
    if (!s_load) ext = '0;
  end

  // Remaining READ_LAT-1 stages; reset drops everything in flight
  logic        pv_q [PIPE_N];
  logic [31:0] pd_q [PIPE_N];
  logic        pe_q [PIPE_N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_N; i++) begin
        pv_q[i] <= 1'b0;
        pd_q[i] <= '0;
        pe_q[i] <= 1'b0;
      end
    end else begin
      pv_q[0] <= s_valid;
      pd_q[0] <= ext;
      pe_q[0] <= s_err;
      for (int i = 1; i < PIPE_N; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
    end
  end

  assign bus.rsp_valid = (READ_LAT == 1) ? s_valid : pv_q[PIPE_N-1];
  assign bus.rsp_rdata = (READ_LAT == 1) ? ext     : pd_q[PIPE_N-1];
  assign bus.rsp_err   = (READ_LAT == 1) ? s_err   : pe_q[PIPE_N-1];

  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

endmodule

// File: tb/tb_data_mem_pipe.sv
// Bench for data_mem_pipe: three configurations share one stimulus driver; per-instance
// monitors pop expected {cycle, err, rdata} entries as responses appear.
module tb_data_mem_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic rst_a, rst_b, rst_c;
  logic fs_a, fs_b, fs_c;

  data_mem_pipe_if ia ();
  data_mem_pipe_if ib ();
  data_mem_pipe_if ic ();

  int          sel;
  logic        drv_valid, drv_we, drv_uns;
  logic [1:0]  drv_size;
  logic [31:0] drv_addr, drv_wdata;

  assign ia.req_valid = drv_valid && (sel == 0);
  assign ib.req_valid = drv_valid && (sel == 1);
  assign ic.req_valid = drv_valid && (sel == 2);
  assign ia.req_we = drv_we;       assign ib.req_we = drv_we;       assign ic.req_we = drv_we;
  assign ia.req_size = drv_size;   assign ib.req_size = drv_size;   assign ic.req_size = drv_size;
  assign ia.req_unsigned = drv_uns; assign ib.req_unsigned = drv_uns; assign ic.req_unsigned = drv_uns;
  assign ia.req_addr = drv_addr;   assign ib.req_addr = drv_addr;   assign ic.req_addr = drv_addr;
  assign ia.req_wdata = drv_wdata; assign ib.req_wdata = drv_wdata; assign ic.req_wdata = drv_wdata;

  data_mem_pipe #(.ADDR_W(16), .READ_LAT(1), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ia), .fsm_state(fs_a));
  data_mem_pipe #(.ADDR_W(16), .READ_LAT(3), .CLEAR_ON_RESET(0)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ib), .fsm_state(fs_b));
  data_mem_pipe #(.ADDR_W(6), .READ_LAT(1), .CLEAR_ON_RESET(1)) dut_c (
    .clk(clk), .rst(rst_c), .bus(ic), .fsm_state(fs_c));

  // Entry layout: {expected cycle[31:0], err, rdata[31:0]}
  logic [64:0] exp_q_a[$];
  logic [64:0] exp_q_b[$];
  logic [64:0] exp_q_c[$];
  int n_rsp[3];
  int n_exp[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cmp_rsp(input string nm, input logic [64:0] e, input logic err,
                         input logic [31:0] rd);
    checks++;
    if ({err, rd} !== e[32:0] || cyc != int'(e[64:33])) begin
      errors++;
      $display("FAIL rsp_%s: got err=%0b rdata=%h cyc=%0d want err=%0b rdata=%h cyc=%0d",
               nm, err, rd, cyc, e[32], e[31:0], e[64:33]);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] rd);
    checks++;
    errors++;
    $display("FAIL rsp_%s_unexpected: got rsp_valid=1 rdata=%h cyc=%0d want no response", nm, rd, cyc);
  endtask

  always @(negedge clk) if (ia.rsp_valid === 1'b1) begin
    n_rsp[0]++;
    if (exp_q_a.size() == 0) unexpected("a", ia.rsp_rdata);
    else cmp_rsp("a", exp_q_a.pop_front(), ia.rsp_err, ia.rsp_rdata);
  end

  always @(negedge clk) if (ib.rsp_valid === 1'b1) begin
    n_rsp[1]++;
    if (exp_q_b.size() == 0) unexpected("b", ib.rsp_rdata);
    else cmp_rsp("b", exp_q_b.pop_front(), ib.rsp_err, ib.rsp_rdata);
  end

  always @(negedge clk) if (ic.rsp_valid === 1'b1) begin
    n_rsp[2]++;
    if (exp_q_c.size() == 0) unexpected("c", ic.rsp_rdata);
    else cmp_rsp("c", exp_q_c.pop_front(), ic.rsp_err, ic.rsp_rdata);
  end

  function automatic logic ready_of(input int d);
    case (d)
      0:       return ia.req_ready;
      1:       return ib.req_ready;
      default: return ic.req_ready;
    endcase
  endfunction

  function automatic int lat_of(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  // Drives one request from a negedge; it is accepted on the following posedge
  task automatic issue(input int d, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input bit track);
    int waited;
    logic [64:0] e;
    @(negedge clk);
    sel = d; drv_valid = 1'b1; drv_we = we; drv_size = size; drv_uns = uns;
    drv_addr = addr; drv_wdata = wdata;
    waited = 0;
    while (!ready_of(d) && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_of(d)) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout_%0d: got req_ready=0 for %0d cycles want 1", d, waited);
      drv_valid = 1'b0;
      return;
    end
    if (track) begin
      e = {32'(cyc + lat_of(d)), exp_err, exp_rd};
      n_exp[d]++;
      case (d)
        0:       exp_q_a.push_back(e);
        1:       exp_q_b.push_back(e);
        default: exp_q_c.push_back(e);
      endcase
    end
  endtask

  task automatic st(input int d, input logic [1:0] size, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic exp_err);
    issue(d, 1'b1, size, 1'b0, addr, wdata, 32'h0, exp_err, 1'b1);
  endtask

  task automatic ld(input int d, input logic [1:0] size, input logic uns,
                    input logic [31:0] addr, input logic [31:0] exp_rd, input logic exp_err);
    issue(d, 1'b0, size, uns, addr, 32'h0, exp_rd, exp_err, 1'b1);
  endtask

  task automatic drain(input int n);
    @(negedge clk);
    drv_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic sweep_len(input string nm);
    int n;
    n = 0;
    #1;
    while (!ic.req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(nm, n, 16);
  endtask

  initial begin
    sel = 0; drv_valid = 1'b0; drv_we = 1'b0; drv_size = 2'd0; drv_uns = 1'b0;
    drv_addr = '0; drv_wdata = '0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (3) @(negedge clk);

    chk("a_rst_valid", {31'd0, ia.rsp_valid}, 0);
    chk("a_rst_rdata", ia.rsp_rdata, 0);
    chk("a_rst_err",   {31'd0, ia.rsp_err}, 0);
    chk("a_rst_ready", {31'd0, ia.req_ready}, 0);
    chk("b_rst_valid", {31'd0, ib.rsp_valid}, 0);
    chk("b_rst_rdata", ib.rsp_rdata, 0);
    chk("b_rst_ready", {31'd0, ib.req_ready}, 0);
    chk("c_rst_valid", {31'd0, ic.rsp_valid}, 0);
    chk("c_rst_ready", {31'd0, ic.req_ready}, 0);

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #1;
    chk("b_ready_run", {31'd0, ib.req_ready}, 1);
    chk("c_state_init", {31'd0, fs_c}, 0);

    // B: READ_LAT=3 back-to-back loads, then reset with loads in flight
    st(1, 2'd2, 32'h0, 32'h1111_1111, 1'b0);
    st(1, 2'd2, 32'h4, 32'h2222_2222, 1'b0);
    st(1, 2'd2, 32'h8, 32'h3333_3333, 1'b0);
    ld(1, 2'd2, 1'b0, 32'h0, 32'h1111_1111, 1'b0);
    ld(1, 2'd2, 1'b0, 32'h4, 32'h2222_2222, 1'b0);
    ld(1, 2'd2, 1'b0, 32'h8, 32'h3333_3333, 1'b0);
    drain(6);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_b = 1'b1;
    sel = 1; drv_valid = 1'b1; drv_we = 1'b1; drv_size = 2'd2; drv_addr = 32'h0;
    drv_wdata = 32'hFFFF_FFFF;
    #1;
    chk("b_ready_in_rst", {31'd0, ib.req_ready}, 0);
    @(negedge clk);
    rst_b = 1'b0; drv_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("b_flushed_rsp_count", n_rsp[1], 6);
    ld(1, 2'd2, 1'b0, 32'h0, 32'h1111_1111, 1'b0);
    ld(1, 2'd2, 1'b0, 32'h4, 32'h2222_2222, 1'b0);
    drain(6);

    // C: ADDR_W=6 init sweep length, clearing and restart on mid-sweep reset
    st(2, 2'd2, 32'h3C, 32'hCAFE_F00D, 1'b0);
    st(2, 2'd2, 32'h00, 32'h1234_5678, 1'b0);
    ld(2, 2'd2, 1'b0, 32'h3C, 32'hCAFE_F00D, 1'b0);
    drain(3);
    rst_c = 1'b1;
    #1;
    chk("c_ready_in_rst", {31'd0, ic.req_ready}, 0);
    @(negedge clk);
    rst_c = 1'b0;
    sweep_len("c_sweep_len");
    chk("c_state_run", {31'd0, fs_c}, 1);
    ld(2, 2'd2, 1'b0, 32'h3C, 32'h0, 1'b0);
    ld(2, 2'd2, 1'b0, 32'h00, 32'h0, 1'b0);
    drain(3);
    rst_c = 1'b1;
    @(negedge clk);
    rst_c = 1'b0;
    repeat (5) @(negedge clk);
    rst_c = 1'b1;
    @(negedge clk);
    rst_c = 1'b0;
    sweep_len("c_sweep_restart_len");

    // A: ADDR_W=16, READ_LAT=1 functional vectors (waits out the initial sweep)
    st(0, 2'd2, 32'h100, 32'hDEAD_BEEF, 1'b0);
    ld(0, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b0);
    st(0, 2'd2, 32'h200, 32'h1122_3344, 1'b0);
    st(0, 2'd0, 32'h203, 32'h0000_0080, 1'b0);
    ld(0, 2'd0, 1'b0, 32'h203, 32'hFFFF_FF80, 1'b0);
    ld(0, 2'd0, 1'b1, 32'h203, 32'h0000_0080, 1'b0);
    ld(0, 2'd2, 1'b0, 32'h200, 32'h8022_3344, 1'b0);
    st(0, 2'd1, 32'h202, 32'hABCD_8001, 1'b0);
    ld(0, 2'd1, 1'b0, 32'h202, 32'hFFFF_8001, 1'b0);
    ld(0, 2'd1, 1'b1, 32'h202, 32'h0000_8001, 1'b0);
    ld(0, 2'd2, 1'b0, 32'h200, 32'h8001_3344, 1'b0);
    st(0, 2'd0, 32'h201, 32'h1234_56F0, 1'b0);
    ld(0, 2'd0, 1'b0, 32'h201, 32'hFFFF_FFF0, 1'b0);
    ld(0, 2'd0, 1'b1, 32'h200, 32'h0000_0044, 1'b0);
    ld(0, 2'd1, 1'b0, 32'h200, 32'hFFFF_F044, 1'b0);
    ld(0, 2'd2, 1'b0, 32'h200, 32'h8001_F044, 1'b0);
    st(0, 2'd2, 32'h101, 32'h1234_5678, 1'b1);
    ld(0, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b0);
    ld(0, 2'd1, 1'b0, 32'h001, 32'h0, 1'b1);
    ld(0, 2'd3, 1'b0, 32'h000, 32'h0, 1'b1);
    st(0, 2'd3, 32'h104, 32'h0000_0055, 1'b1);
    ld(0, 2'd2, 1'b0, 32'h104, 32'h0, 1'b0);
    ld(0, 2'd2, 1'b0, 32'h102, 32'h0, 1'b1);
    st(0, 2'd1, 32'h203, 32'h0000_7777, 1'b1);
    ld(0, 2'd2, 1'b0, 32'h200, 32'h8001_F044, 1'b0);
    st(0, 2'd2, 32'h0001_0010, 32'hA5A5_A5A5, 1'b0);
    ld(0, 2'd2, 1'b0, 32'h10, 32'hA5A5_A5A5, 1'b0);
    ld(0, 2'd0, 1'b1, 32'hFFFF_0013, 32'h0000_00A5, 1'b0);
    drain(6);

    chk("a_q_empty", exp_q_a.size(), 0);
    chk("b_q_empty", exp_q_b.size(), 0);
    chk("c_q_empty", exp_q_c.size(), 0);
    chk("a_rsp_count", n_rsp[0], n_exp[0]);
    chk("b_rsp_count", n_rsp[1], n_exp[1]);
    chk("c_rsp_count", n_rsp[2], n_exp[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
